// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-bit validation, mid-bit sampling, and parity/framing/overrun
// reporting. Received words are handed over through a one-entry valid/ready holding register.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 half_bit, mid_bit, deliver, ferr_final, perr_sample;

  assign half_bit    = tick && (scnt == SW'(OVERSAMPLE/2 - 1));
  assign mid_bit     = tick && (scnt == SW'(OVERSAMPLE - 1));
  assign ferr_final  = ferr | ~rx_s;
  assign perr_sample = (PARITY == 1) ? ~(^{shreg, rx_s}) : (^{shreg, rx_s});
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    case (state)
      IDLE:  if (tick && !rx_s) state_next = START;
      START: if (half_bit) state_next = rx_s ? IDLE : DATA;
      DATA:  if (mid_bit && bit_idx == BW'(DATA_BITS - 1))
               state_next = (PARITY != 0) ? PAR : STOP;
      PAR:   if (mid_bit) state_next = STOP;
      STOP:  if (mid_bit && stop_idx == 1'(STOP_BITS - 1)) begin
               deliver    = 1'b1;
               state_next = ferr_final ? BREAK : IDLE;
             end
      BREAK: if (tick && rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Synchroniser resets high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      scnt     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      if (state_next != state || state == IDLE) scnt <= '0;
      else if (tick)                            scnt <= scnt + 1'b1;
      case (state)
        START: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
        DATA: if (mid_bit) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        PAR:  if (mid_bit) perr <= perr_sample;
        STOP: if (mid_bit) begin
          ferr     <= ferr_final;
          stop_idx <= stop_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A delivery into a full, unaccepted holding register is dropped and flagged as overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= (PARITY != 0) ? perr : 1'b0;
          frame_err  <= ferr_final;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and a 7-bit even-parity instance,
// with tick asserted every other clk cycle.
module tb_uart_rx_os;

  logic       clk = 1'b0, tick = 1'b0;
  logic       rst, rx_a, rx_p, rdy_a, rdy_p;
  logic [7:0] data_a;
  logic [6:0] data_p;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       valid_p, perr_p, ferr_p, ovr_p, busy_p;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_p), .rx_data(data_p), .rx_valid(valid_p),
    .rx_ready(rdy_p), .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p));

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = ~tick;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every handshake transfer is matched against the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_a && rdy_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_a: got data %0h with no delivery expected", data_a);
        end else begin
          e = q_a.pop_front();
          if ({data_a, perr_a, ferr_a} !== {e.data[7:0], e.perr, e.ferr}) begin
            errors++;
            $display("[TB] FAIL word_a: got data %0h perr %0b ferr %0b expected data %0h perr %0b ferr %0b",
                     data_a, perr_a, ferr_a, e.data[7:0], e.perr, e.ferr);
          end
        end
      end
      if (valid_p && rdy_p) begin
        checks++;
        if (q_p.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_p: got data %0h with no delivery expected", data_p);
        end else begin
          e = q_p.pop_front();
          if ({data_p, perr_p, ferr_p} !== {e.data[6:0], e.perr, e.ferr}) begin
            errors++;
            $display("[TB] FAIL word_p: got data %0h perr %0b ferr %0b expected data %0h perr %0b ferr %0b",
                     data_p, perr_p, ferr_p, e.data[6:0], e.perr, e.ferr);
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_p = v;
    else       rx_a = v;
  endtask

  task automatic apply_frame(input bit which, input logic [8:0] data, input int nbits,
                             input bit par_en, input logic par, input logic stop,
                             input logic after);
    set_rx(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, data[i]);
      wait_ticks(16);
    end
    if (par_en) begin
      set_rx(which, par);
      wait_ticks(16);
    end
    set_rx(which, stop);
    wait_ticks(16);
    set_rx(which, after);
    wait_ticks(4);
  endtask

  task automatic push_exp(input bit which, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    if (which) q_p.push_back(e);
    else       q_a.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((q_a.size() != 0 || q_p.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_output(name, q_a.size() + q_p.size(), 0);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_p = 1'b1; rdy_a = 1'b1; rdy_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", valid_a, 0);
    check_output("reset_data", data_a, 0);
    check_output("reset_flags", {perr_a, ferr_a, ovr_a}, 0);
    check_output("reset_busy", busy_a, 0);
    rst = 1'b0;
    wait_ticks(4);

    // Two clean 8N1 words back to back.
    push_exp(0, 9'h0A5, 0, 0);
    apply_frame(0, 9'h0A5, 8, 0, 0, 1, 1);
    push_exp(0, 9'h03C, 0, 0);
    apply_frame(0, 9'h03C, 8, 0, 0, 1, 1);
    wait_drain("drain_clean", 200);
    check_output("clean_busy", busy_a, 0);
    check_output("clean_overrun", ovr_a, 0);

    // A 5-tick glitch is rejected at the start-bit centre.
    set_rx(0, 1'b0);
    wait_ticks(3);
    check_output("glitch_busy_high", busy_a, 1);
    wait_ticks(2);
    set_rx(0, 1'b1);
    wait_ticks(12);
    check_output("glitch_busy_low", busy_a, 0);

    // A low stop bit gives a framing error, then a held-low line stays in BREAK.
    push_exp(0, 9'h03C, 0, 1);
    apply_frame(0, 9'h03C, 8, 0, 0, 0, 0);
    wait_ticks(40);
    check_output("break_busy", busy_a, 1);
    set_rx(0, 1'b1);
    wait_ticks(4);
    check_output("break_exit", busy_a, 0);
    push_exp(0, 9'h096, 0, 0);
    apply_frame(0, 9'h096, 8, 0, 0, 1, 1);
    wait_drain("drain_break", 200);

    // 7E1: 0x07 has three ones, so the correct even-parity bit is 1.
    push_exp(1, 9'h007, 1, 0);
    apply_frame(1, 9'h007, 7, 1, 0, 1, 1);
    push_exp(1, 9'h007, 0, 0);
    apply_frame(1, 9'h007, 7, 1, 1, 1, 1);
    wait_drain("drain_parity", 200);

    // Overrun: second word dropped while the first is held.
    rdy_a = 1'b0;
    push_exp(0, 9'h011, 0, 0);
    apply_frame(0, 9'h011, 8, 0, 0, 1, 1);
    apply_frame(0, 9'h022, 8, 0, 0, 1, 1);
    check_output("ovr_data_held", data_a, 8'h11);
    check_output("ovr_valid", valid_a, 1);
    check_output("ovr_flag", ovr_a, 1);
    rdy_a = 1'b1;
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    check_output("ovr_valid_cleared", valid_a, 0);
    check_output("ovr_flag_cleared", ovr_a, 0);
    rdy_a = 1'b1;
    push_exp(0, 9'h033, 0, 0);
    apply_frame(0, 9'h033, 8, 0, 0, 1, 1);
    wait_drain("drain_overrun", 200);

    // Reset in the middle of the data bits discards the frame.
    set_rx(0, 1'b0);
    wait_ticks(16);
    set_rx(0, 1'b0); wait_ticks(16);
    set_rx(0, 1'b1); wait_ticks(16);
    set_rx(0, 1'b0); wait_ticks(8);
    rst = 1'b1;
    rx_a = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("midrst_valid", valid_a, 0);
    check_output("midrst_data", data_a, 0);
    check_output("midrst_busy", busy_a, 0);
    check_output("midrst_flags", {perr_a, ferr_a, ovr_a}, 0);
    wait_ticks(20);
    check_output("midrst_idle", busy_a, 0);
    push_exp(0, 9'h05A, 0, 0);
    apply_frame(0, 9'h05A, 8, 0, 0, 1, 1);
    wait_drain("drain_after_reset", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver. It is the successor to the fixed 8-bit, one-sample-per-bit receiver used in the loopback BIST path.
- Adds configurable data width, parity, stop bits and oversampling ratio.
- Samples each bit at mid-bit and rejects false starts.
- Reports parity, framing and overrun errors.
- Hands bytes to the consumer through a one-entry valid/ready holding register.
- Sits between baud_rate_generator (tick output) and the comparator/golden-ROM checker or user logic.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- OVERSAMPLE, 16, ticks per bit period; power of two, minimum 8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-clk-wide enable at baud*OVERSAMPLE; all bit timing advances only on tick
- rx_in  in  1  asynchronous serial line; idle high
- rx_data  out  DATA_BITS  received payload, LSB = first bit on the wire
- rx_valid  out  1  rx_data and its error flags are valid
- rx_ready  in  1  consumer accepts; a transfer occurs on a cycle with rx_valid & rx_ready
- parity_err  out  1  parity mismatch for the held byte; always 0 when PARITY = 0
- frame_err  out  1  at least one stop bit was sampled low for the held byte
- overrun  out  1  a completed byte was dropped because the holding register was full
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- **Input synchroniser.** rx_in passes through a 2-FF synchroniser (rx_s), reset value 1. All decisions use rx_s.
- **Reset state.** rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0. State = IDLE, tick counter = 0, bit index = 0.
- **Reset mid-frame.** The partial frame is discarded and nothing is delivered.
- **Counter.** scnt is log2(OVERSAMPLE) bits wide. It increments on tick and clears on every state change.
- **States:** IDLE, START, DATA, PAR, STOP, BREAK. The clk cycles between ticks hold all state.
- **IDLE:** on a tick with rx_s = 0, go to START with scnt = 0.
- **START:** on the tick where scnt = OVERSAMPLE/2 - 1 (start-bit centre):
  - rx_s = 1: false start, return to IDLE with no output.
  - rx_s = 0: clear scnt and go to DATA with bit index = 0.
- **DATA:** on the tick where scnt = OVERSAMPLE - 1 (one bit period later, i.e. mid-bit):
  - shift rx_s into the shift register, LSB first, and increment the bit index;
  - after DATA_BITS samples, go to PAR if PARITY != 0, otherwise go to STOP.
- **PAR:** sample the parity bit at mid-bit.
  - Odd parity: the XOR of data and parity must be 1.
  - Even parity: the XOR must be 0.
  - A mismatch latches an internal perr.
- **STOP:** sample STOP_BITS bits at mid-bit. Any low sample sets an internal ferr. On the final stop sample, deliver the frame:
  - ferr = 0: go to IDLE on the same tick, so a start bit immediately after the stop centre is caught.
  - ferr = 1: go to BREAK.
- **BREAK:** stay until a tick with rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering continuous frames.
- **Delivery.** Happens in the clk cycle of the final stop-sample tick; the outputs update on the next edge.
  - Holding register empty, or rx_valid & rx_ready in the same cycle: load rx_data, parity_err and frame_err. rx_valid = 1.
  - Otherwise (full and not accepted): drop the new byte, keep the held byte and its flags unchanged, and set overrun = 1.
- **Error frames.** Frames with parity_err or frame_err are still delivered with their flags.
- **Handshake.**
  - rx_valid stays high until the cycle after rx_valid & rx_ready, unless a new delivery occurs in that same cycle.
  - rx_data must not change while rx_valid = 1 and no transfer occurs.
- **overrun** is sticky. It clears on the cycle after a transfer, or on rst.
- **Latency.** rx_valid rises 1 clk after the final stop-sample tick. Measured from the rx_in pins this is 3 clk plus the tick alignment, because of the synchroniser.
- **tick held high continuously.** This is legal and gives OVERSAMPLE clk cycles per bit.

Test Plan:
1. 8N1, OVERSAMPLE = 16, send 0xA5 then 0x3C with rx_ready = 1 -> rx_valid pulses twice with rx_data = 0xA5 then 0x3C; parity_err, frame_err and overrun all 0; busy returns to 0.
2. Drive a low glitch of 5 ticks on an idle line -> START samples high, no rx_valid, state returns to IDLE, busy low within 8 ticks.
3. Send 0x3C with stop bit low, then hold the line low for 40 ticks -> one delivery with rx_data = 0x3C and frame_err = 1; no further rx_valid until the line returns high and a new frame arrives.
4. PARITY = 2 (even), DATA_BITS = 7: send 0x07 with parity bit 0 (wrong) -> parity_err = 1. Resend with parity bit 1 -> parity_err = 0 and rx_data = 0x07.
5. rx_ready = 0, send 0x11 then 0x22 -> rx_data remains 0x11 and overrun = 1. Pulse rx_ready for 1 cycle -> rx_valid = 0 and overrun = 0. Send 0x33 -> rx_data = 0x33.
6. Assert rst for 1 clk in the middle of the DATA bits of a frame -> no delivery; all outputs at reset values. The following clean 0x5A frame is received correctly.
